dmem_responder: RTL and testbench
=================================

# dmem_responder

Single-port data memory that responds on the core's data request bus (`data_req`/`data_gnt`/`data_valid`). It is the target the LSU drives: it grants requests, performs byte-enabled writes and word reads, and returns exactly one in-order response per grant. It sits at the data side of the core in the simulation and FPGA top level, in place of a bus fabric. Optional grant wait states let the LSU's hold-until-grant and unaligned two-beat paths be exercised.

## Interface
Parameters:
- `DEPTH`, 1024: number of 32-bit words; must be a power of two.
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0; word-aligned.
- `GNT_WAIT`, 0: wait cycles inserted before each grant, range 0–15. Used only with `DMEM_WAIT_EN`.

Ports (one clock; `reset_n` asynchronous, active-low):
- `clk`  in  1  core clock.
- `reset_n`  in  1  asynchronous active-low reset.
- `data_req`  in  1  request; held with all request fields until granted.
- `data_wr`  in  1  1 = write, 0 = read.
- `data_addr`  in  32  byte address; bits [1:0] are ignored.
- `data_wdata`  in  32  write data, already lane-replicated by the requester.
- `data_be`  in  4  byte enables; apply to writes only.
- `data_gnt`  out  1  request accepted this cycle.
- `data_rdata`  out  32  read data, meaningful while `data_valid` is 1.
- `data_valid`  out  1  one-cycle response strobe.
- `data_error`  out  1  error response, qualified by `data_valid`.

## Operation
- Address decode uses 32-bit modular arithmetic: `off = data_addr - BASE_ADDR`. The address is in range iff `off < DEPTH*4` (unsigned). Word index is `off[log2(DEPTH)+1:2]`.
- Accepted transaction = `data_req & data_gnt`.
- Accepted write, in range: each byte lane i with `data_be[i]` = 1 is updated with `data_wdata[8i+7:8i]` at the granting clock edge. `data_be` = 0 changes nothing and still gets a normal response.
- Accepted read, in range: the addressed word is sampled at the grant edge.
- Out-of-range access, read or write: memory is not modified, and the response has `data_error` = 1 and `data_rdata` = 0.
- Write responses return `data_rdata` = 0 and `data_error` = 0 when in range.
- Read-after-write to the same word in the next transaction returns the newly written data. A transaction never observes its own write.
- Responses are strictly in order, one per grant, never merged or dropped except by reset.

## Timing
- Reset values: `data_gnt` 0, `data_valid` 0, `data_rdata` 0, `data_error` 0, wait counter 0. Memory contents are not reset.
- `data_gnt` is combinational from `data_req` and the wait counter.
- Response: `data_valid` is registered and asserted exactly 1 cycle after the grant cycle, for 1 cycle.
  - Back-to-back grants produce back-to-back valids.
  - The first beat of an unaligned pair therefore responds while the second beat is still waiting for its grant.
- Wait-state counter (with `DMEM_WAIT_EN`), states IDLE and WAIT:
  - IDLE → WAIT when `data_req` = 1, `GNT_WAIT` > 0 and no grant is issued.
  - In WAIT the counter increments every cycle `data_req` is held.
  - `data_gnt` = `data_req & (cnt == GNT_WAIT)`.
  - On a grant the counter clears and the FSM returns to IDLE, so the next request waits the full `GNT_WAIT` again.
  - `data_req` dropping before grant (protocol violation) clears the counter; no response is issued.
- `GNT_WAIT` = 0 means grant in the same cycle as `data_req`.
- Reset asserted mid-wait or with a response pending: the counter clears and the pending response is discarded; no `data_valid` after reset release until a new grant.

## Configuration
- `DMEM_WAIT_EN` defined: the wait-state FSM and counter are built, and `GNT_WAIT` applies.
- `DMEM_WAIT_EN` undefined: `data_gnt` = `data_req`, no counter logic is built, and `GNT_WAIT` is ignored. Response timing is unchanged (grant + 1).

## Structure
- Shared package `riscv_pkg` holds:
  - the `DMEM_GNT_WAIT_MAX` (15) constant;
  - the `dmem_state_e` typedef (IDLE, WAIT).
- Sub-module `dmem_sram`: a `DEPTH`×32 array with a synchronous read port and a 4-lane byte-write port (`we`, `be`, `idx`, `wdata`, `rdata`).
- `dmem_responder` holds the address decode, wait FSM, and response registers.

## Test plan
- Write 0x1234_5678 to 0x10 with `be`=1111, then read 0x10 → `data_valid` 1 cycle after each grant, read `data_rdata` = 0x1234_5678, `data_error` = 0.
- Preload 0x0000_0000 at 0x4, write `wdata` = 0xABAB_ABAB with `be`=0010 → read of 0x4 returns 0x0000_AB00.
- Read at `BASE_ADDR` + `DEPTH`*4, and at `BASE_ADDR` − 4 (wrap) → `data_error` = 1, `data_rdata` = 0. A write to the same address leaves the memory unchanged (checked by read-back of word 0 and of word `DEPTH`−1).
- `DMEM_WAIT_EN`, `GNT_WAIT` = 2, `data_req` held from cycle 0 → `data_gnt` at cycle 2 only, `data_valid` at cycle 3. An immediate second request is granted at cycle 5.
- `GNT_WAIT` = 0, four consecutive reads of 0x0, 0x4, 0x8, 0xC → grants in cycles 0–3, valids in cycles 1–4, data in order.
- Assert `reset_n` = 0 in the cycle after a grant → `data_valid` stays 0 through and after reset until the next grant. All outputs are 0 during reset.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared core package: data-memory wait-state limit and wait FSM state type.
package riscv_pkg;

  localparam int unsigned DMEM_GNT_WAIT_MAX = 15;
  localparam int unsigned DMEM_CNT_W        = 4;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } dmem_state_e;

endpackage

// File: rtl/dmem_sram.sv
// DEPTH x 32 single-port array: synchronous read, 4-lane byte write.
// The read returns the word as it was before a same-edge write.
module dmem_sram #(
  parameter int unsigned DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [3:0]               be,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata
);

  logic [31:0] mem [DEPTH];

  // Byte-lane write and registered read of the addressed word
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    rdata <= mem[idx];
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-side memory target: grants requests, performs byte-enabled writes and
// word reads, and returns one in-order response per grant (grant + 1 cycle).
// Optional grant wait states are built when DMEM_WAIT_EN is defined.
module dmem_responder
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned GNT_WAIT  = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_be,
  output logic        data_gnt,
  output logic [31:0] data_rdata,
  output logic        data_valid,
  output logic        data_error
);

  localparam int unsigned IDX_W      = $clog2(DEPTH);
  localparam logic [31:0] SIZE_BYTES = 32'(DEPTH * 4);

  logic [31:0]      off;
  logic             in_range;
  logic [IDX_W-1:0] idx;
  logic             gnt_c;
  logic             mem_we;
  logic [31:0]      sram_rdata;
  logic             valid_q;
  logic             error_q;
  logic             rsel_q;

  // Modular address decode relative to the base address
  assign off      = data_addr - BASE_ADDR;
  assign in_range = (off < SIZE_BYTES);
  assign idx      = off[IDX_W+1:2];

`ifdef DMEM_WAIT_EN
  localparam logic [DMEM_CNT_W-1:0] WAIT_CYC =
    DMEM_CNT_W'((GNT_WAIT > DMEM_GNT_WAIT_MAX) ? DMEM_GNT_WAIT_MAX : GNT_WAIT);

  dmem_state_e           state_q, state_d;
  logic [DMEM_CNT_W-1:0] cnt_q, cnt_d;

  // Wait FSM state and counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Grant once the counter reaches the wait count; clear on grant or dropped req
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_c   = data_req & (cnt_q == WAIT_CYC);
    case (state_q)
      IDLE: begin
        if (data_req && !gnt_c) begin
          state_d = WAIT;
          cnt_d   = cnt_q + DMEM_CNT_W'(1);
        end
      end
      WAIT: begin
        if (!data_req || gnt_c) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + DMEM_CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end
`else
  logic unused_gnt_wait;
  assign unused_gnt_wait = 1'(GNT_WAIT % 2);
  assign gnt_c           = data_req;
`endif

  // Nothing is granted while reset is held
  assign data_gnt = gnt_c & reset_n;
  assign mem_we   = data_gnt & data_wr & in_range;

  dmem_sram #(
    .DEPTH (DEPTH)
  ) u_sram (
    .clk   (clk),
    .we    (mem_we),
    .be    (data_be),
    .idx   (idx),
    .wdata (data_wdata),
    .rdata (sram_rdata)
  );

  // Response registers: one strobe per grant, error for out-of-range
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      error_q <= 1'b0;
      rsel_q  <= 1'b0;
    end else begin
      valid_q <= data_gnt;
      error_q <= data_gnt & ~in_range;
      rsel_q  <= data_gnt & ~data_wr & in_range;
    end
  end

  // Read data only for in-range reads; writes and errors return zero
  assign data_valid = valid_q;
  assign data_error = error_q;
  assign data_rdata = rsel_q ? sram_rdata : 32'h0;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder against a word-array reference model.
module tb_dmem_responder;

  localparam int unsigned DEPTH    = 64;
  localparam logic [31:0] BASE     = 32'h0000_0000;
  localparam int unsigned GNT_WAIT = 2;
`ifdef DMEM_WAIT_EN
  localparam int unsigned EXP_WAIT = GNT_WAIT;
`else
  localparam int unsigned EXP_WAIT = 0;
`endif

  logic        clk;
  logic        reset_n;
  logic        data_req;
  logic        data_wr;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_be;
  logic        data_gnt;
  logic [31:0] data_rdata;
  logic        data_valid;
  logic        data_error;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] model [DEPTH];
  logic        q_wr    [$];
  logic [31:0] q_addr  [$];
  logic [31:0] q_wdata [$];
  logic [3:0]  q_be    [$];
  logic [31:0] last_rdata;
  logic        last_error;

  dmem_responder #(
    .DEPTH     (DEPTH),
    .BASE_ADDR (BASE),
    .GNT_WAIT  (GNT_WAIT)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .data_req   (data_req),
    .data_wr    (data_wr),
    .data_addr  (data_addr),
    .data_wdata (data_wdata),
    .data_be    (data_be),
    .data_gnt   (data_gnt),
    .data_rdata (data_rdata),
    .data_valid (data_valid),
    .data_error (data_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic wr, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
    q_wr.push_back(wr);
    q_addr.push_back(a);
    q_wdata.push_back(wd);
    q_be.push_back(be);
  endtask

  task automatic drive(input int i);
    data_req   = 1'b1;
    data_wr    = q_wr[i];
    data_addr  = q_addr[i];
    data_wdata = q_wdata[i];
    data_be    = q_be[i];
  endtask

  // Reference: decode, respond, then apply the write to the word array
  task automatic model_access(input int i, output logic [31:0] rd, output logic er);
    logic [31:0] off;
    int unsigned w;
    off = q_addr[i] - BASE;
    rd  = 32'h0;
    er  = 1'b0;
    if (off >= 32'(DEPTH * 4)) begin
      er = 1'b1;
    end else begin
      w = int'(off / 4);
      if (q_wr[i]) begin
        for (int b = 0; b < 4; b++)
          if (q_be[i][b]) model[w][8*b +: 8] = q_wdata[i][8*b +: 8];
      end else begin
        rd = model[w];
      end
    end
  endtask

  // Issue the queued transactions back to back, checking grant and response each cycle
  task automatic run_seq();
    int n, i, waited, budget;
    bit pend;
    logic [31:0] pr;
    logic pe;
    n = q_wr.size();
    i = 0; waited = 0; pend = 0; pr = '0; pe = 1'b0;
    budget = n * (EXP_WAIT + 3) + 10;
    @(posedge clk); #1;
    if (n > 0) drive(0); else data_req = 1'b0;
    while ((i < n || pend) && budget > 0) begin
      @(negedge clk);
      budget--;
      if (pend) begin
        check("rsp_valid", 32'(data_valid), 32'h1);
        check("rsp_rdata", data_rdata, pr);
        check("rsp_error", 32'(data_error), 32'(pe));
        last_rdata = data_rdata;
        last_error = data_error;
      end else begin
        check("idle_valid", 32'(data_valid), 32'h0);
      end
      pend = 0;
      if (i < n) begin
        check("gnt", 32'(data_gnt), 32'(waited == int'(EXP_WAIT)));
        if (data_gnt) begin
          model_access(i, pr, pe);
          pend = 1;
          i++;
          waited = 0;
        end else begin
          waited++;
        end
      end else begin
        check("gnt_noreq", 32'(data_gnt), 32'h0);
      end
      @(posedge clk); #1;
      if (i < n) drive(i); else data_req = 1'b0;
    end
    if (budget <= 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL timeout: observed %0d of %0d granted, required all", i, n);
    end
    data_req = 1'b0;
    @(negedge clk);
    check("tail_valid", 32'(data_valid), 32'h0);
    q_wr.delete(); q_addr.delete(); q_wdata.delete(); q_be.delete();
  endtask

  initial begin
    int r;
    logic [31:0] a;
    reset_n = 1'b1; data_req = 1'b0; data_wr = 1'b0;
    data_addr = '0; data_wdata = '0; data_be = '0;
    last_rdata = '0; last_error = 1'b0;
    #2 reset_n = 1'b0;
    data_req = 1'b1;
    @(negedge clk);
    check("rst_gnt", 32'(data_gnt), 32'h0);
    check("rst_valid", 32'(data_valid), 32'h0);
    check("rst_rdata", data_rdata, 32'h0);
    check("rst_error", 32'(data_error), 32'h0);
    @(posedge clk); #1 data_req = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;

    // Fill every word so the model and the array agree from here on
    for (int w = 0; w < int'(DEPTH); w++) push(1'b1, BASE + 32'(w * 4), $urandom, 4'hF);
    run_seq();

    // Full-word write then read back
    push(1'b1, 32'h10, 32'h1234_5678, 4'hF);
    push(1'b0, 32'h10, 32'h0, 4'h0);
    run_seq();
    check("tp_rd10", last_rdata, 32'h1234_5678);
    check("tp_rd10_err", 32'(last_error), 32'h0);

    // Single-lane write over a zeroed word; zero enables change nothing
    push(1'b1, 32'h4, 32'h0, 4'hF);
    push(1'b1, 32'h4, 32'hABAB_ABAB, 4'b0010);
    push(1'b1, 32'h4, 32'hFFFF_FFFF, 4'b0000);
    push(1'b0, 32'h6, 32'h0, 4'h0);
    run_seq();
    check("tp_rd4", last_rdata, 32'h0000_AB00);

    // Out-of-range reads and writes above the top and below the base
    push(1'b0, BASE + 32'(DEPTH * 4), 32'h0, 4'h0);
    push(1'b0, BASE - 32'h4, 32'h0, 4'h0);
    push(1'b1, BASE + 32'(DEPTH * 4), 32'hDEAD_BEEF, 4'hF);
    push(1'b1, BASE - 32'h4, 32'hDEAD_BEEF, 4'hF);
    push(1'b0, BASE, 32'h0, 4'h0);
    push(1'b0, BASE + 32'((DEPTH - 1) * 4), 32'h0, 4'h0);
    run_seq();

    // Consecutive reads of the first four words
    for (int w = 0; w < 4; w++) push(1'b0, 32'(w * 4), 32'h0, 4'h0);
    run_seq();

    // Random mix, including ignored low address bits and out-of-range hits
    for (int k = 0; k < 60; k++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0)      a = BASE + 32'(DEPTH * 4) + 32'($urandom_range(0, 255));
      else if (r == 1) a = BASE - 32'($urandom_range(1, 64));
      else             a = BASE + 32'($urandom_range(0, DEPTH * 4 - 1));
      push(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
    end
    run_seq();

    // Reset in the cycle after a grant discards the pending response
    @(posedge clk); #1;
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h10; data_be = 4'h0;
    for (int c = 0; c < 20 && !data_gnt; c++) @(negedge clk);
    check("rst_pre_gnt", 32'(data_gnt), 32'h1);
    @(posedge clk); #1 reset_n = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("rstm_valid", 32'(data_valid), 32'h0);
      check("rstm_gnt", 32'(data_gnt), 32'h0);
      check("rstm_rdata", data_rdata, 32'h0);
      check("rstm_error", 32'(data_error), 32'h0);
    end
    @(posedge clk); #1 data_req = 1'b0; reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("post_rst_valid", 32'(data_valid), 32'h0);
    end

    // Normal operation resumes with memory intact
    push(1'b0, 32'h10, 32'h0, 4'h0);
    push(1'b0, 32'h4, 32'h0, 4'h0);
    run_seq();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
